ula_pixel_fetch: RTL and testbench

ULA_PIXEL_FETCH -- requirements
Module: ula_pixel_fetch

---
 rtl/ula_pixel_fetch.sv | 136 +++++++++++++
 tb/tb_ula_pixel_fetch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ula_pixel_fetch.sv
// ZX Spectrum ULA video fetch: VRAM bitmap/attribute reads, 8-bit pixel shifter, colour output.
// Optional Timex per-line attribute addressing is enabled by defining TIMEX_HICOLOR_EN.
module ula_pixel_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clken,
  input  logic [8:0]  hcnt,
  input  logic [8:0]  vcnt,
  input  logic [2:0]  border,
  input  logic        hicolor,
  output logic [13:0] vram_addr,
  output logic        vram_rd,
  input  logic [7:0]  vram_data,
  output logic [2:0]  ri,
  output logic [2:0]  gi,
  output logic [2:0]  bi
);

  logic        active_s;
  logic [13:0] bmp_addr_s;
  logic [13:0] attr_addr_s;
  logic [7:0]  bmp_latch_r;
  logic [7:0]  attr_latch_r;
  logic [7:0]  shift_r;
  logic [7:0]  attr_r;
  logic        disp_r;
  logic [4:0]  flash_r;
  logic [2:0]  border_r;
  logic        pix_s;
  logic [2:0]  grb_s;
  logic [2:0]  r_nxt_s;
  logic [2:0]  g_nxt_s;
  logic [2:0]  b_nxt_s;

  function automatic logic [2:0] level(input logic on, input logic bright);
    logic [2:0] l;
    if (!on) begin
      l = 3'b000;
    end else if (bright) begin
      l = 3'b111;
    end else begin
      l = 3'b101;
    end
    return l;
  endfunction

  assign active_s   = (hcnt[8] == 1'b0) && (vcnt < 9'd192);
  assign bmp_addr_s = {1'b0, vcnt[7:6], vcnt[2:0], vcnt[5:3], hcnt[7:3]};

`ifdef TIMEX_HICOLOR_EN
  // Hi-colour mode: one attribute byte per bitmap byte, mirrored in the upper 8K.
  assign attr_addr_s = hicolor ? (bmp_addr_s | 14'h2000) : {4'b0110, vcnt[7:3], hcnt[7:3]};
`else
  logic unused_hicolor_s;
  assign unused_hicolor_s = hicolor;
  assign attr_addr_s      = {4'b0110, vcnt[7:3], hcnt[7:3]};
`endif

  // VRAM request: bitmap on cell pixel 0, attribute on cell pixel 1, address otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vram_addr <= 14'h0000;
      vram_rd   <= 1'b0;
    end else if (clken) begin
      if (active_s && (hcnt[2:0] == 3'd0)) begin
        vram_rd   <= 1'b1;
        vram_addr <= bmp_addr_s;
      end else if (active_s && (hcnt[2:0] == 3'd1)) begin
        vram_rd   <= 1'b1;
        vram_addr <= attr_addr_s;
      end else begin
        vram_rd   <= 1'b0;
      end
    end
  end

  // Data latches, shifter/attribute load at cell end, flash counter and border register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bmp_latch_r  <= 8'h00;
      attr_latch_r <= 8'h00;
      shift_r      <= 8'h00;
      attr_r       <= 8'h00;
      disp_r       <= 1'b0;
      flash_r      <= 5'd0;
      border_r     <= 3'b000;
    end else if (clken) begin
      border_r <= border;
      if ((hcnt == 9'd0) && (vcnt == 9'd0)) begin
        flash_r <= flash_r + 5'd1;
      end
      case (hcnt[2:0])
        3'd1: bmp_latch_r <= vram_data;
        3'd2: attr_latch_r <= vram_data;
        default: begin
        end
      endcase
      if (hcnt[2:0] == 3'd7) begin
        shift_r <= bmp_latch_r;
        attr_r  <= attr_latch_r;
        disp_r  <= active_s;
      end else begin
        shift_r <= {shift_r[6:0], 1'b0};
      end
    end
  end

  // Colour select: ink/paper with flash inversion inside the display, plain border outside.
  always_comb begin
    pix_s = shift_r[7] ^ (attr_r[7] & flash_r[4]);
    grb_s = pix_s ? attr_r[2:0] : attr_r[5:3];
    if (disp_r) begin
      g_nxt_s = level(grb_s[2], attr_r[6]);
      r_nxt_s = level(grb_s[1], attr_r[6]);
      b_nxt_s = level(grb_s[0], attr_r[6]);
    end else begin
      g_nxt_s = level(border_r[2], 1'b0);
      r_nxt_s = level(border_r[1], 1'b0);
      b_nxt_s = level(border_r[0], 1'b0);
    end
  end

  // Registered colour outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ri <= 3'b000;
      gi <= 3'b000;
      bi <= 3'b000;
    end else if (clken) begin
      ri <= r_nxt_s;
      gi <= g_nxt_s;
      bi <= b_nxt_s;
    end
  end

endmodule

// File: tb/tb_ula_pixel_fetch.sv
// Self-checking bench for ula_pixel_fetch: directed pins plus randomized raster against an event-history model.
module tb_ula_pixel_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clken = 1'b0;
  logic [8:0]  hcnt = 9'd0;
  logic [8:0]  vcnt = 9'd0;
  logic [2:0]  border = 3'b000;
  logic        hicolor = 1'b0;
  logic [13:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_data;
  logic [2:0]  ri, gi, bi;

  logic [7:0] mem [0:16383];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign vram_data = mem[vram_addr];

  ula_pixel_fetch dut (
    .clk(clk), .rst_n(rst_n), .clken(clken), .hcnt(hcnt), .vcnt(vcnt),
    .border(border), .hicolor(hicolor), .vram_addr(vram_addr), .vram_rd(vram_rd),
    .vram_data(vram_data), .ri(ri), .gi(gi), .bi(bi)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: history of enabled clock edges ----------------
  typedef struct { int h; int v; int bdr; int hc; int data; } ev_t;
  ev_t hist[$];
  int  exp_addr = 0, exp_rd = 0, exp_rgb = 0, frames = 0;

  function automatic int lvl(int on, int br);
    return on ? (br ? 7 : 5) : 0;
  endfunction

  function automatic int is_act(int h, int v);
    return (h < 256 && v < 192) ? 1 : 0;
  endfunction

  function automatic int bmp_addr(int h, int v);
    return (((v >> 6) & 3) << 11) | ((v & 7) << 8) | (((v >> 3) & 7) << 5) | ((h >> 3) & 31);
  endfunction

  function automatic int attr_addr(int h, int v, int hc);
`ifdef TIMEX_HICOLOR_EN
    if (hc != 0) return bmp_addr(h, v) | 'h2000;
`endif
    return 'h1800 | (((v >> 3) & 31) << 5) | ((h >> 3) & 31);
  endfunction

  function automatic int grb_rgb(int grb, int br);
    return (lvl((grb >> 1) & 1, br) << 6) | (lvl((grb >> 2) & 1, br) << 3) | lvl(grb & 1, br);
  endfunction

  task automatic model_step(input int h, input int v, input int bdr, input int hc);
    ev_t e;
    int j, bm, at, k, bitv, pix, prev_b, n;
    n = hist.size();
    prev_b = (n > 0) ? hist[n-1].bdr : 0;
    j = -1;
    for (int i = n - 1; i >= 0; i--) if (hist[i].h % 8 == 7) begin j = i; break; end
    if (j < 0 || is_act(hist[j].h, hist[j].v) == 0) begin
      exp_rgb = grb_rgb(prev_b, 0);
    end else begin
      bm = 0;
      at = 0;
      for (int i = j - 1; i >= 0; i--) if (hist[i].h % 8 == 1) begin bm = hist[i].data; break; end
      for (int i = j - 1; i >= 0; i--) if (hist[i].h % 8 == 2) begin at = hist[i].data; break; end
      k = n - j - 1;
      bitv = (k < 8) ? ((bm >> (7 - k)) & 1) : 0;
      pix = bitv ^ (((at >> 7) & 1) & ((frames >> 4) & 1));
      exp_rgb = grb_rgb(pix ? (at & 7) : ((at >> 3) & 7), (at >> 6) & 1);
    end
    e.h = h; e.v = v; e.bdr = bdr; e.hc = hc; e.data = mem[exp_addr];
    hist.push_back(e);
    if (h == 0 && v == 0) frames++;
    if (is_act(h, v) != 0 && h % 8 == 0) begin
      exp_rd = 1; exp_addr = bmp_addr(h, v);
    end else if (is_act(h, v) != 0 && h % 8 == 1) begin
      exp_rd = 1; exp_addr = attr_addr(h, v, hc);
    end else begin
      exp_rd = 0;
    end
  endtask

  // Compare process: snapshot inputs at the edge, advance the model, check outputs.
  initial forever begin
    logic s_rst, s_en, s_hc;
    logic [8:0] s_h, s_v;
    logic [2:0] s_b;
    @(posedge clk);
    s_rst = rst_n; s_en = clken; s_h = hcnt; s_v = vcnt; s_b = border; s_hc = hicolor;
    #2;
    if (!s_rst) begin
      hist.delete();
      exp_addr = 0; exp_rd = 0; exp_rgb = 0; frames = 0;
    end else if (s_en) begin
      model_step(int'(s_h), int'(s_v), int'(s_b), int'(s_hc));
    end
    check("vram_addr", {18'd0, vram_addr}, exp_addr);
    check("vram_rd", {31'd0, vram_rd}, exp_rd);
    check("rgb", {23'd0, ri, gi, bi}, exp_rgb);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int h, input int v, input bit gap);
    if (gap) while ($urandom_range(0, 3) == 0) begin @(negedge clk); clken = 1'b0; end
    @(negedge clk);
    clken = 1'b1; hcnt = h[8:0]; vcnt = v[8:0];
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic run_line(input int v, input int h0, input int h1, input bit rnd);
    for (int h = h0; h <= h1; h++) begin
      if (rnd && $urandom_range(0, 63) == 0) border = 3'($urandom);
      cyc(h, v, rnd);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; clken = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic flash_cell(input int exp);
    for (int h = 0; h <= 15; h++) begin
      cyc(h, 8, 0);
      if (h == 12) begin settle(); check("flash_cell", {23'd0, ri, gi, bi}, exp); end
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    do_reset();

    // fetch addresses at the top-left cell
    cyc(0, 0, 0); settle();
    check("fetch0_addr", {18'd0, vram_addr}, 32'h0000); check("fetch0_rd", {31'd0, vram_rd}, 1);
    cyc(1, 0, 0); settle();
    check("fetch1_addr", {18'd0, vram_addr}, 32'h1800); check("fetch1_rd", {31'd0, vram_rd}, 1);
    cyc(2, 0, 0); settle();
    check("fetch2_rd", {31'd0, vram_rd}, 0);

    // pixel timing: bitmap 0x81 with bright white ink on black paper
    mem[14'h0902] = 8'h81; mem[14'h1902] = 8'h47;
    for (int h = 8; h <= 32; h++) begin
      cyc(h, 65, 0); settle();
      if (h == 16) check("pix_bmp_addr", {18'd0, vram_addr}, 32'h0902);
      if (h == 17) check("pix_attr_addr", {18'd0, vram_addr}, 32'h1902);
      if (h >= 24 && h <= 31) check("pix_col", {23'd0, ri, gi, bi}, (h == 24 || h == 31) ? 9'o777 : 9'o000);
    end

    // flash: paper white / ink black, swaps after 16 frames and back after 32
    do_reset();
    mem[14'h0020] = 8'h00; mem[14'h1820] = 8'hB8;
    flash_cell(9'o555);
    repeat (16) cyc(0, 0, 0);
    flash_cell(9'o000);
    repeat (16) cyc(0, 0, 0);
    flash_cell(9'o555);

    // border outside the display and at both line ends
    border = 3'b010;
    for (int h = 0; h <= 447; h++) begin
      cyc(h, 200, 0);
      if (h == 100) begin settle(); check("border_v200", {23'd0, ri, gi, bi}, 9'o500); end
    end
    for (int h = 0; h <= 447; h++) begin
      cyc(h, 10, 0);
      if (h == 3 || h == 270) begin settle(); check("border_v10", {23'd0, ri, gi, bi}, 9'o500); end
    end

    // hi-colour attribute address
    hicolor = 1'b1;
    cyc(8, 1, 0); cyc(9, 1, 0); settle();
`ifdef TIMEX_HICOLOR_EN
    check("hicolor_addr", {18'd0, vram_addr}, 32'h2101);
`else
    check("hicolor_addr", {18'd0, vram_addr}, 32'h1801);
`endif
    hicolor = 1'b0;

    // reset mid-line, then resume
    run_line(20, 0, 100, 0);
    @(negedge clk);
    rst_n = 1'b0; clken = 1'b0;
    #1;
    check("rst_rgb", {23'd0, ri, gi, bi}, 0);
    check("rst_rd", {31'd0, vram_rd}, 0);
    check("rst_addr", {18'd0, vram_addr}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_line(20, 101, 447, 0);

    // randomized raster with clock-enable gaps, border changes and frame/line wraps
    run_line(191, 0, 447, 1);
    run_line(192, 0, 447, 1);
    for (int l = 0; l < 10; l++) begin
      hicolor = 1'($urandom);
      run_line((l == 3) ? 0 : $urandom_range(0, 311), 0, 447, 1);
    end

    @(negedge clk); clken = 1'b0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
